// File: rtl/l0_skew_feeder_if.sv
// Vector-side bundle of the west-edge feeder: upstream valid/ready input plus skewed array-facing outputs.
// The master side is the reader/array environment; the slave side is the feeder.
interface l0_skew_feeder_if #(
    parameter int bw  = 4,
    parameter int row = 8
);
    logic [row*bw-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [row*bw-1:0] out_w;
    logic [2*row-1:0]  inst_w;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_w,
        input  inst_w
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_w,
        output inst_w
    );
endinterface

// File: rtl/l0_skew_feeder.sv
// West-edge feeder: buffers a col-vector kernel and issues it as one burst, then streams activations.
// Lane r shows an issued vector 1+r cycles later; in_ready is registered, high only while filling or executing.
module l0_skew_feeder #(
    parameter int bw     = 4,
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int len_bw = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              exec_start,
    input  logic [len_bw-1:0] exec_len,
    output logic              busy,
    output logic              done,
    l0_skew_feeder_if.slave   bus
);
    localparam int VW    = row * bw;
    localparam int CNT_W = $clog2(col + 1);
    localparam int IDX_W = (col > 1) ? $clog2(col) : 1;
    localparam int DRN_W = $clog2(row + 1);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(col - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'((row > 1) ? row - 2 : 0);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_FILL,
        LOAD_ISSUE,
        EXEC,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [len_bw-1:0]  len_q, len_d;
    logic [DRN_W-1:0]   drn_q, drn_d;
    logic [VW-1:0]      hold_q, hold_d;
    logic               in_ready_q, in_ready_d;
    logic               done_q, done_d;
    logic [VW-1:0]      buf_q [col];
    logic [VW-1:0]      buf_d [col];

    logic [IDX_W-1:0]   idx;
    logic               xfer;
    logic               last_iss;
    logic [VW-1:0]      iss_dat;
    logic [1:0]         iss_inst;

    assign idx  = cnt_q[IDX_W-1:0];
    assign xfer = bus.in_valid && in_ready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        drn_d    = drn_q;
        done_d   = 1'b0;
        buf_d    = buf_q;
        iss_dat  = hold_q;
        iss_inst = 2'b00;
        last_iss = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD_FILL;
                    cnt_d   = '0;
                end else if (exec_start) begin
                    len_d = exec_len;
                    if (exec_len == '0) begin
                        last_iss = 1'b1;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            LOAD_FILL: begin
                if (xfer) begin
                    buf_d[idx] = bus.in_data;
                    if (cnt_q == COL_LAST) begin
                        state_d = LOAD_ISSUE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LOAD_ISSUE: begin
                iss_dat  = buf_q[idx];
                iss_inst = 2'b11;
                if (cnt_q == COL_LAST) begin
                    last_iss = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EXEC: begin
                // Empty cycles still issue a bubble so the diagonal timing stays intact.
                if (xfer) begin
                    iss_dat  = bus.in_data;
                    iss_inst = 2'b10;
                    len_d    = len_q - len_bw'(1);
                    if (len_q == len_bw'(1)) begin
                        last_iss = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drn_q == DRN_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    drn_d = drn_q + DRN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // done must land when lane row-1 shows the final issue, row cycles after it.
        if (last_iss) begin
            if (row == 1) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = DRAIN;
                drn_d   = '0;
            end
        end

        hold_d     = iss_dat;
        in_ready_d = (state_d == LOAD_FILL) || (state_d == EXEC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            drn_q      <= '0;
            hold_q     <= '0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            drn_q      <= drn_d;
            hold_q     <= hold_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
        end
    end

    // Kernel storage is always fully rewritten before it is issued, so it needs no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign bus.in_ready = in_ready_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

    for (genvar r = 0; r < row; r++) begin : g_lane
        logic [bw-1:0] dat_q [r+1];
        logic [bw-1:0] dat_d [r+1];
        logic [1:0]    ins_q [r+1];
        logic [1:0]    ins_d [r+1];

        always_comb begin
            dat_d[0] = iss_dat[r*bw +: bw];
            ins_d[0] = iss_inst;
            for (int k = 1; k <= r; k++) begin
                dat_d[k] = dat_q[k-1];
                ins_d[k] = ins_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k <= r; k++) begin
                    dat_q[k] <= '0;
                    ins_q[k] <= '0;
                end
            end else begin
                dat_q <= dat_d;
                ins_q <= ins_d;
            end
        end

        assign bus.out_w[r*bw +: bw] = dat_q[r];
        assign bus.inst_w[2*r +: 2]  = ins_q[r];
    end
endmodule
